bcd_report_sched: RTL
=====================

# bcd_report_sched

Round-robin scheduler that shares one serial 12-bit binary-to-BCD converter among `N_CH` measurement requesters and streams each result as an ASCII report line to the UART transmitter. It sits in the uart subsystem, between the status/measurement sources (frame counters, Sobel threshold, etc.) and the byte-wide UART TX input. It owns the converter's start/capture sequencing and the TX byte handshake.

## Interface
- `N_CH`, 4: number of requesters (2..8).
- `ZERO_PAD`, 1: 1 = leading zero digits sent as '0'; 0 = leading zeros sent as ASCII space (0x20); the units digit is always sent as a digit.
- `TMO`, 31: cycles allowed from converter start to converter valid before the report is aborted.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `req`  in  N_CH  level request per channel.
- `din`  in  N_CH*12  channel i value at `din[12*i+11:12*i]`.
- `ack`  out  N_CH  one-cycle pulse; `din` for the granted channel was latched.
- `tx_data`  out  8  ASCII byte.
- `tx_valid`  out  1  byte offered.
- `tx_ready`  in  1  UART TX accepts; a transfer occurs on `tx_valid && tx_ready`.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse on converter timeout.

## Operation
- FSM states: IDLE, START, CONV, SEND.
- IDLE:
  - If any `req` is high, grant the first requesting channel searching upward (with wrap) from last_grant+1.
  - Latch its 12-bit value, set last_grant, and go to START.
- START (1 cycle):
  - `ack[grant]`=1.
  - Converter `start`=1 with the latched value.
  - Load the timeout counter with 0; go to CONV.
- CONV:
  - Counter increments each cycle.
  - On converter `valid`, capture the 16-bit BCD in that same cycle and go to SEND. The converter clears `bcd` the cycle after `valid`, so capture is mandatory.
  - If the counter reaches TMO first: pulse `err`, discard the report, go to IDLE.
- SEND: emit 7 bytes in order, byte index 0..6:
  - Byte 0: 'A'+grant (0x41+grant).
  - Bytes 1..4: BCD digits, thousands down to units, each 0x30+digit; leading zeros follow `ZERO_PAD`.
  - Byte 5: CR (0x0D). Byte 6: LF (0x0A).
  - After the byte 6 transfer, go to IDLE.
- Arithmetic: input range 0..4095, so the thousands digit is ≤4 and BCD[15:12] uses 3 significant bits. Digit→ASCII is a 4-bit add into an 8-bit result; no carry is possible.
- Requests are sampled only in IDLE. Deasserting `req` after grant does not cancel the report. A request held high is served again only after the other pending channels (round robin).
- Reset values: `ack`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `err`=0, state=IDLE, last_grant=N_CH-1 (channel 0 wins first), byte index=0.
- Asynchronous reset mid-report aborts immediately. No partial byte is completed, and the converter is also reset by the same `nrst`.

## Timing
- Cycle 0: IDLE with `req` high. Cycle 1: START (`ack`, converter start).
- Cycle 14: converter `valid` (13 cycles after start); BCD captured.
- Cycle 15: `tx_valid`=1, `tx_data`=tag.
- `tx_data` holds stable while `tx_valid && !tx_ready`. `tx_valid` never drops without a transfer.
- The next byte is presented in the cycle after each transfer. With `tx_ready` tied high, the line occupies cycles 15..21.
- First IDLE is cycle 22. The earliest next START is cycle 23 (one-cycle IDLE minimum).
- `busy` is high cycles 1..21.
- `err`, when it occurs, pulses in the cycle where the counter equals TMO; state is IDLE the next cycle.

## Structure
- Shared uart package:
  - Constants `ASCII_ZERO`=0x30, `ASCII_SPACE`=0x20, `ASCII_A`=0x41, `ASCII_CR`=0x0D, `ASCII_LF`=0x0A, `REPORT_LEN`=7.
  - The FSM state enum.
- One sub-module instance: `bin2bcd_c`, the team's serial 12-bit converter.
  - Inputs: `start` pulse and `bin`.
  - Outputs: `bcd[15:0]` and a one-cycle `valid`.
- The round-robin arbiter stays inline as a function.

## Test plan
- Single request: `req`=0001, value 1234, `tx_ready`=1 → `ack[0]` in cycle 1; bytes 41 31 32 33 34 0D 0A in cycles 15..21.
- Boundaries: `ZERO_PAD`=0 with value 7 on ch2 → 43 20 20 20 37 0D 0A. Value 0 → 20 20 20 30. Value 4095 → 34 30 39 35.
- Round robin: `req`=1011 held continuously → grant order 0,1,3,0,1,3. Each grant's `ack` arrives one cycle after the previous line's LF plus one IDLE cycle.
- Backpressure: `tx_ready` low for 5 cycles on byte 2 → `tx_data` is stable throughout, with no duplicated or skipped bytes.
- Timeout: force converter `valid` low → `err` pulses 31 cycles after START, no bytes are sent, and the next request is served normally.
- Reset mid-SEND after byte 3 → all outputs are 0 the same cycle. A post-reset request produces a complete fresh line starting with channel 0's priority.

Source files
------------

// File: rtl/bcd_report_sched_pkg.sv
// Shared uart constants and the report scheduler FSM encoding.
package bcd_report_sched_pkg;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam int         REPORT_LEN  = 7;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_CONV, ST_SEND} state_t;
endpackage

// File: rtl/bcd_report_sched_bin2bcd.sv
// Serial 12-bit binary-to-BCD converter (double dabble, one bit per cycle).
// valid pulses 13 cycles after start; bcd is only meaningful while valid is high.
module bcd_report_sched_bin2bcd (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [11:0] bin,
  output logic [15:0] bcd,
  output logic        valid
);
  logic [27:0] sh, sh_nxt;
  logic [3:0]  step;
  logic        run;

  // One iteration: add 3 to every BCD nibble >= 5, then shift the next binary bit in.
  always_comb begin
    sh_nxt = sh;
    for (int d = 0; d < 4; d++)
      if (sh[12+4*d +: 4] >= 4'd5) sh_nxt[12+4*d +: 4] = sh[12+4*d +: 4] + 4'd3;
    sh_nxt = sh_nxt << 1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sh    <= '0;
      step  <= '0;
      run   <= 1'b0;
      bcd   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (valid) bcd <= '0;
      if (start) begin
        sh   <= {16'd0, bin};
        step <= '0;
        run  <= 1'b1;
      end else if (run) begin
        sh   <= sh_nxt;
        step <= step + 4'd1;
        if (step == 4'd11) begin
          run   <= 1'b0;
          valid <= 1'b1;
          bcd   <= sh_nxt[27:12];
        end
      end
    end
  end
endmodule

// File: rtl/bcd_report_sched.sv
// Round-robin scheduler sharing one serial bin2bcd among N_CH requesters and
// streaming each result as a 7-byte ASCII line ("<tag><4 digits>\r\n") to UART TX.
module bcd_report_sched
  import bcd_report_sched_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ZERO_PAD = 1,
  parameter int TMO      = 31
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [N_CH-1:0]     req,
  input  logic [N_CH*12-1:0]  din,
  output logic [N_CH-1:0]     ack,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                err
);
  localparam int GW = $clog2(N_CH);
  localparam int CW = $clog2(TMO + 1);

  state_t        state;
  logic [GW-1:0] last_grant, pick;
  logic [11:0]   value;
  logic [CW-1:0] cnt;
  logic [15:0]   bcd_q, conv_bcd;
  logic [2:0]    idx;
  logic          conv_start, conv_valid;

  function automatic logic [GW-1:0] rr_pick(input logic [N_CH-1:0] r, input logic [GW-1:0] last);
    logic [GW-1:0] p;
    p = last;
    // Walk from farthest to nearest so the channel right after last wins.
    for (int k = N_CH; k >= 1; k--)
      if (r[(int'(last) + k) % N_CH]) p = GW'((int'(last) + k) % N_CH);
    return p;
  endfunction

  function automatic logic [7:0] report_byte(input logic [2:0] i, input logic [GW-1:0] ch,
                                             input logic [15:0] b);
    logic [15:0] upper;
    logic [7:0]  r;
    upper = '0;
    r     = ASCII_LF;
    case (i)
      3'd0: r = ASCII_A + 8'(ch);
      3'd1, 3'd2, 3'd3, 3'd4: begin
        // Digit lands in the low nibble; nothing set above it means a leading zero.
        upper = b >> (4 * (4 - int'(i)));
        r = (ZERO_PAD == 0 && i != 3'd4 && upper == 16'd0) ? ASCII_SPACE
                                                           : ASCII_ZERO + {4'd0, upper[3:0]};
      end
      3'd5:    r = ASCII_CR;
      default: r = ASCII_LF;
    endcase
    return r;
  endfunction

  assign pick       = rr_pick(req, last_grant);
  assign conv_start = (state == ST_START);
  assign busy       = (state != ST_IDLE);

  bcd_report_sched_bin2bcd bin2bcd_c (
    .clk   (clk),
    .nrst  (nrst),
    .start (conv_start),
    .bin   (value),
    .bcd   (conv_bcd),
    .valid (conv_valid)
  );

  // cnt counts cycles since START; err is registered so it shows while cnt == TMO.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      last_grant <= GW'(N_CH - 1);
      value      <= '0;
      cnt        <= '0;
      bcd_q      <= '0;
      idx        <= '0;
      ack        <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      err        <= 1'b0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        ST_IDLE: if (|req) begin
          last_grant <= pick;
          value      <= din[12*int'(pick) +: 12];
          ack[pick]  <= 1'b1;
          cnt        <= '0;
          state      <= ST_START;
        end
        ST_START: begin
          cnt   <= cnt + 1'b1;
          state <= ST_CONV;
        end
        ST_CONV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(TMO)) begin
            state <= ST_IDLE;
          end else if (conv_valid) begin
            bcd_q    <= conv_bcd;
            tx_valid <= 1'b1;
            tx_data  <= report_byte(3'd0, last_grant, conv_bcd);
            idx      <= '0;
            state    <= ST_SEND;
          end else if (cnt == CW'(TMO - 1)) begin
            err <= 1'b1;
          end
        end
        ST_SEND: if (tx_ready) begin
          if (idx == 3'(REPORT_LEN - 1)) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            idx      <= '0;
            state    <= ST_IDLE;
          end else begin
            idx     <= idx + 3'd1;
            tx_data <= report_byte(idx + 3'd1, last_grant, bcd_q);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
